// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock mode controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alarm_clock_pkg;

  // 3-bit state encoding; 3'd7 is unused and recovers to SHOW_TIME
  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  // Keypad code meaning "no key pressed"; digits are 0-9
  localparam logic [3:0] NOKEY = 4'd10;

  // Default number of idle one_second pulses before key entry is abandoned
  localparam int unsigned TIMEOUT_SEC_DEFAULT = 10;

  // True in the states where the inactivity timeout is running
  function automatic logic is_entry_state(input state_t s);
    return (s == KEY_WAITED) || (s == KEY_ENTRY);
  endfunction

endpackage

// File: rtl/key_timeout_counter.sv
// Saturating 4-bit inactivity counter for key entry.
// Latency: count updates one clock after tick; timeout is combinational from count.
// Backpressure: none; tick is sampled every cycle.
module key_timeout_counter #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic timeout
);

  localparam logic [3:0] LIMIT = 4'(TIMEOUT_SEC);

  logic [3:0] count;

  // Clear outside key entry; otherwise count ticks and hold at the limit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (enable && tick && (count != LIMIT)) begin
      count <= count + 4'd1;
    end
  end

  assign timeout = (count == LIMIT);

endmodule

// File: rtl/alarm_fsm.sv
// Alarm clock mode controller: keypad/button events to shift, load and display strobes.
// Latency: outputs registered, they change on the edge that enters the new state.
// Backpressure: none; inputs are sampled every cycle and outputs are strobes/levels.
module alarm_fsm
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = TIMEOUT_SEC_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       time_button,
  input  logic       alarm_button,
  output logic       shift,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_a,
  output logic       show_new_time
);

  state_t state;
  state_t next_state;
  logic   counting;
  logic   timeout;
  logic   key_pressed;

  assign key_pressed = (key != NOKEY);
  assign counting    = is_entry_state(state);

  // The count restarts on every KEY_STORED visit since that state is not counting
  key_timeout_counter #(
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (!counting),
    .enable (counting),
    .tick   (one_second),
    .timeout(timeout)
  );

  // Next-state selection; priority follows the order of the if/else chains
  always_comb begin
    next_state = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)     next_state = SHOW_ALARM;
        else if (key_pressed) next_state = KEY_STORED;
      end
      KEY_STORED: next_state = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_pressed)     next_state = KEY_ENTRY;
        else if (timeout)     next_state = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     next_state = SET_ALARM_TIME;
        else if (time_button) next_state = SET_CURRENT_TIME;
        else if (key_pressed) next_state = KEY_STORED;
        else if (timeout)     next_state = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button)    next_state = SHOW_TIME;
      end
      SET_ALARM_TIME:   next_state = SHOW_TIME;
      SET_CURRENT_TIME: next_state = SHOW_TIME;
      default:          next_state = SHOW_TIME;
    endcase
  end

  // State register with outputs registered from the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= SHOW_TIME;
      shift         <= 1'b0;
      load_new_c    <= 1'b0;
      load_new_a    <= 1'b0;
      show_a        <= 1'b0;
      show_new_time <= 1'b0;
    end else begin
      state         <= next_state;
      shift         <= (next_state == KEY_STORED);
      load_new_c    <= (next_state == SET_CURRENT_TIME);
      load_new_a    <= (next_state == SET_ALARM_TIME);
      show_a        <= (next_state == SHOW_ALARM);
      show_new_time <= (next_state == KEY_STORED) || is_entry_state(next_state);
    end
  end

endmodule
